instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

Multi-cycle instruction fetch and main control stage that sits directly upstream of the register-file/ALU/data-memory datapath. Fetches 32-bit instructions over a req/ready handshake, holds them in an instruction register, drives the datapath's register-select fields, immediate, function code and control strobes, and updates the PC from the datapath `Zero` flag and jump targets.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high; sampled on the rising edge of `clk`.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, equal to PC.
- `imem_ready` in 1: instruction memory has valid data on `imem_data`.
- `imem_data` in 32: fetched instruction.
- `Zero` in 1: ALU zero flag from the datapath.
- `rs`, `rt`, `rd` out 5 each: IR[25:21], IR[20:16], IR[15:11].
- `SEin` out 16: IR[15:0].
- `FuncCode` out 6: IR[5:0].
- `Regsel` out 1: 1 selects `rd` as the write register, 0 selects `rt`.
- `ALUsel` out 1: 1 selects the sign-extended immediate as ALU operand B.
- `ALUOp` out 2: 00 add, 01 subtract, 10 use the function code.
- `MemWrite` out 2: 00 none, 01 byte, 10 halfword, 11 word.
- `MemRead` out 1: data memory read enable.
- `MemToRegSel` out 1: 1 writes memory data back, 0 writes `ALUOut`.
- `RegWrite` out 1: register-file write strobe.
- `pc` out 32: current PC.
- `halt` out 1: illegal opcode seen; sticky until reset.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- **FETCH**
  - `imem_req`=1 and `imem_addr`=PC.
  - While `imem_ready`=0, the block stays in FETCH with address stable.
  - When `imem_ready`=1: IR<=`imem_data`, PC<=PC+4, next state DECODE.
- **DECODE**
  - Fields are valid from IR.
  - `ALUsel`, `ALUOp` and `Regsel` take the values for the opcode. No strobes are asserted.
  - An illegal opcode goes to HALT; all others go to EXEC.
- **EXEC**
  - R-type (0x00): `ALUOp`=10, `ALUsel`=0. Next state WB.
  - addi (0x08): `ALUOp`=00, `ALUsel`=1. Next state WB.
  - lw (0x23): `ALUOp`=00, `ALUsel`=1. Next state MEM.
  - sw (0x2B), sb (0x28), sh (0x29): `ALUOp`=00, `ALUsel`=1. Next state MEM.
  - beq (0x04): `ALUOp`=01, `ALUsel`=0. If `Zero`=1, PC<=PC+(sext(SEin)<<2), using the already-incremented PC. Next state FETCH.
  - j (0x02): PC<={PC[31:28], IR[25:0], 2'b00}. Next state FETCH.
- **MEM**
  - Stores: `MemWrite` is asserted for exactly one cycle (11/01/10 for sw/sb/sh). Next state FETCH.
  - lw: `MemRead`=1. Next state WB.
  - `ALUOp` and `ALUsel` are held from EXEC.
- **WB**
  - `RegWrite`=1 for exactly one cycle.
  - `Regsel`=1 for R-type, 0 otherwise.
  - For lw: `MemToRegSel`=1 and `MemRead`=1 (held). Next state FETCH.
- **HALT**
  - `halt`=1, `imem_req`=0, all strobes 0.
  - Only `rst` leaves this state.
- Control outputs are combinational from state and IR. They are stable for the whole state and glitch-free relative to `clk` edges.
- All PC arithmetic is mod 2^32. Wrap from 32'hFFFF_FFFC to 0 is silent.

## Timing
- **Reset values (while `rst` is high, and after the edge)**
  - PC=`RESET_PC`, IR=0, state=FETCH.
  - `imem_req`=0 while `rst` is high.
  - `RegWrite`=0, `MemWrite`=00, `MemRead`=0, `halt`=0.
  - All field outputs are 0.
- **Cycles per instruction, with `imem_ready` high in the first FETCH cycle**
  - R-type and addi: 4.
  - lw: 5.
  - sw, sb, sh: 4.
  - beq and j: 3.
  - Each FETCH wait cycle adds 1.
- **Reset mid-instruction**
  - A pending store or writeback is abandoned.
  - No strobe is asserted in the cycle following the reset edge.
- **`imem_ready` outside FETCH** is ignored.
- **beq** samples `Zero` only in EXEC.

## Configuration
- `IFC_BNE_EN` defined:
  - Opcode 0x05 (bne) is legal.
  - In EXEC, `ALUOp`=01 and the branch is taken when `Zero`=0. It takes 3 cycles, like beq.
- `IFC_BNE_EN` undefined:
  - 0x05 is illegal and goes to HALT.

## Structure
- Package `ifc_pkg`:
  - Opcode constants.
  - State enum.
  - `ALUOp` encodings (ADD/SUB/FUNC).
  - `MemWrite` encodings (NONE/BYTE/HALF/WORD).
- One sub-module, `main_decoder`:
  - Combinational.
  - Takes opcode, state and `Zero`.
  - Produces the control bundle, next state and the illegal flag.
  - The top level holds PC, IR and the state register.

## Test plan
- Reset with `RESET_PC`=32'h100, `imem_ready`=1 -> first `imem_addr`=32'h100, then `pc`=32'h104 in DECODE, all strobes 0.
- R-type add (32'h0022_1820), `imem_ready` held high -> `RegWrite`=1 with `Regsel`=1 exactly in cycle 4. Next `imem_addr`=PC+4.
- lw (32'h8C43_0008) -> `MemRead`=1 in MEM and WB. `RegWrite`=1 with `MemToRegSel`=1 in cycle 5 only.
- sb (32'hA043_0004) -> `MemWrite`=01 for one cycle in cycle 4. `RegWrite` never asserted.
- beq at PC 32'h200 with offset 16'hFFFF:
  - With `Zero`=1 -> next fetch address 32'h200.
  - With `Zero`=0 -> next fetch address 32'h204.
- Opcode 0x3F -> `halt`=1 after DECODE, `imem_req`=0 permanently. Assert `rst` for one cycle -> fetch resumes at `RESET_PC`.

Source files
------------

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types for the instruction fetch / main control stage: opcodes, FSM states,
// ALU and memory-write encodings, and the control bundle passed from the decoder.
package ifc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_FUNC = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_BYTE = 2'b01,
    MW_HALF = 2'b10,
    MW_WORD = 2'b11
  } memwrite_t;

  typedef enum logic [1:0] {
    PC_HOLD, PC_BRANCH, PC_JUMP
  } pcsel_t;

  typedef struct packed {
    logic      regsel;
    logic      alusel;
    aluop_t    aluop;
    memwrite_t memwrite;
    logic      memread;
    logic      memtoregsel;
    logic      regwrite;
  } ctrl_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Instruction-memory fetch bus: request/address out of the fetch stage,
// ready/data back from the memory.
interface instr_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ready, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_data);
endinterface

// File: rtl/instr_fetch_ctrl_main_decoder.sv
// Combinational main decoder: opcode + state + Zero -> control bundle, next state,
// PC update selection and illegal-opcode flag. Define IFC_BNE_EN to make bne (0x05) legal.
module main_decoder
  import ifc_pkg::*;
(
  input  logic [5:0] opcode,
  input  state_t     state,
  input  logic       zero,
  output ctrl_t      ctrl,
  output state_t     next_state,
  output pcsel_t     pc_sel,
  output logic       illegal
);

`ifdef IFC_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  logic      is_rtype, is_imm, is_load, is_store, is_beq, is_bne, is_jump, br_taken;
  memwrite_t store_size;

  always_comb begin
    is_rtype = (opcode == OP_RTYPE);
    is_load  = (opcode == OP_LW);
    is_store = (opcode == OP_SW) || (opcode == OP_SB) || (opcode == OP_SH);
    is_imm   = (opcode == OP_ADDI) || is_load || is_store;
    is_beq   = (opcode == OP_BEQ);
    is_bne   = BNE_EN && (opcode == OP_BNE);
    is_jump  = (opcode == OP_J);
    illegal  = !(is_rtype || is_imm || is_beq || is_bne || is_jump);
    br_taken = (is_beq && zero) || (is_bne && !zero);
    case (opcode)
      OP_SB:   store_size = MW_BYTE;
      OP_SH:   store_size = MW_HALF;
      OP_SW:   store_size = MW_WORD;
      default: store_size = MW_NONE;
    endcase
  end

  always_comb begin
    ctrl       = '0;
    next_state = S_FETCH;
    pc_sel     = PC_HOLD;
    // Operand selection is a pure function of the opcode once IR is loaded,
    // so it stays stable from DECODE through WB.
    if (state != S_FETCH && state != S_HALT) begin
      ctrl.regsel = is_rtype;
      ctrl.alusel = is_imm;
      ctrl.aluop  = is_rtype ? ALU_FUNC : ((is_beq || is_bne) ? ALU_SUB : ALU_ADD);
    end
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = illegal ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (is_beq || is_bne) begin
          pc_sel     = br_taken ? PC_BRANCH : PC_HOLD;
          next_state = S_FETCH;
        end else if (is_jump) begin
          pc_sel     = PC_JUMP;
          next_state = S_FETCH;
        end else if (is_load || is_store) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        ctrl.memwrite = store_size;
        ctrl.memread  = is_load;
        next_state    = is_load ? S_WB : S_FETCH;
      end
      S_WB: begin
        ctrl.regwrite    = 1'b1;
        ctrl.memread     = is_load;
        ctrl.memtoregsel = is_load;
        next_state       = S_FETCH;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Multi-cycle instruction fetch and main control: holds PC, IR and the FSM state,
// fetches over the imem handshake and drives datapath fields/strobes (see IFC_BNE_EN in main_decoder).
module instr_fetch_ctrl
  import ifc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_fetch_ctrl_if.master        imem,
  input  logic                      Zero,
  output logic [4:0]                rs,
  output logic [4:0]                rt,
  output logic [4:0]                rd,
  output logic [15:0]               SEin,
  output logic [5:0]                FuncCode,
  output logic                      Regsel,
  output logic                      ALUsel,
  output logic [1:0]                ALUOp,
  output logic [1:0]                MemWrite,
  output logic                      MemRead,
  output logic                      MemToRegSel,
  output logic                      RegWrite,
  output logic [31:0]               pc,
  output logic                      halt
);

  state_t      state, state_nxt, dec_next;
  ctrl_t       ctrl, ctrl_vis;
  pcsel_t      pc_sel;
  logic        illegal, halt_q;
  logic [31:0] ir, ir_vis, pc_q, br_off;

  main_decoder u_dec (
    .opcode     (ir[31:26]),
    .state      (state),
    .zero       (Zero),
    .ctrl       (ctrl),
    .next_state (dec_next),
    .pc_sel     (pc_sel),
    .illegal    (illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = dec_next;
    if (state == S_FETCH && !imem.imem_ready) state_nxt = S_FETCH;
  end

  // Branch offset is applied to the already-incremented PC.
  assign br_off = {{14{ir[15]}}, ir[15:0], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      ir     <= '0;
      halt_q <= 1'b0;
    end else begin
      if (state == S_FETCH && imem.imem_ready) begin
        ir   <= imem.imem_data;
        pc_q <= pc_q + 32'd4;
      end else if (pc_sel == PC_BRANCH) begin
        pc_q <= pc_q + br_off;
      end else if (pc_sel == PC_JUMP) begin
        pc_q <= {pc_q[31:28], ir[25:0], 2'b00};
      end
      if (state == S_DECODE && illegal) halt_q <= 1'b1;
    end
  end

  // Everything visible is forced to its reset value while rst is high,
  // independent of whatever state the registers hold before the edge.
  always_comb begin
    ctrl_vis = ctrl;
    ir_vis   = ir;
    if (rst) begin
      ctrl_vis = '0;
      ir_vis   = '0;
    end
  end

  assign imem.imem_req  = (state == S_FETCH) && !rst;
  assign pc             = rst ? RESET_PC : pc_q;
  assign imem.imem_addr = pc;
  assign halt           = halt_q && !rst;

  assign rs          = ir_vis[25:21];
  assign rt          = ir_vis[20:16];
  assign rd          = ir_vis[15:11];
  assign SEin        = ir_vis[15:0];
  assign FuncCode    = ir_vis[5:0];
  assign Regsel      = ctrl_vis.regsel;
  assign ALUsel      = ctrl_vis.alusel;
  assign ALUOp       = ctrl_vis.aluop;
  assign MemWrite    = ctrl_vis.memwrite;
  assign MemRead     = ctrl_vis.memread;
  assign MemToRegSel = ctrl_vis.memtoregsel;
  assign RegWrite    = ctrl_vis.regwrite;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed program in a small ROM, expected
// events queued by the stimulus and checked by an independent negedge monitor.
module tb_instr_fetch_ctrl;

  localparam int K_RST = 0, K_FETCH = 1, K_DEC = 2, K_WB = 3, K_MEM = 4, K_HALT = 5;
  localparam logic [63:0] M_ALL   = '1;
  localparam logic [63:0] M_NOALU = 64'h0000_01F1_FFFF_FFFF;
  localparam logic [63:0] M_STRB  = 64'h0000_01F0_FFFF_FFFF;

  typedef struct {
    int          kind;
    logic [63:0] data;
    logic [63:0] mask;
  } exp_t;

  logic        clk, rst, Zero;
  logic [4:0]  rs, rt, rd;
  logic [15:0] SEin;
  logic [5:0]  FuncCode;
  logic        Regsel, ALUsel, MemRead, MemToRegSel, RegWrite, halt;
  logic [1:0]  ALUOp, MemWrite;
  logic [31:0] pc;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   icyc = 0;
  int   stall_cnt = 0;
  int   beq_seen = 0;
  bit   dec_next = 1'b0;
  bit   halt_seen = 1'b0;

  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .imem(bus), .Zero(Zero),
    .rs(rs), .rt(rt), .rd(rd), .SEin(SEin), .FuncCode(FuncCode),
    .Regsel(Regsel), .ALUsel(ALUsel), .ALUOp(ALUOp), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemToRegSel(MemToRegSel), .RegWrite(RegWrite),
    .pc(pc), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h100: return 32'h0022_1820;  // add  r3,r1,r2
      32'h104: return 32'h8C43_0008;  // lw   r3,8(r2)
      32'h108: return 32'hA043_0004;  // sb   r3,4(r2)
      32'h10C: return 32'h0800_0080;  // j    0x200
      32'h200: return 32'h1000_FFFF;  // beq  r0,r0,-1
      32'h204: return 32'h2001_0005;  // addi r1,r0,5
      32'h208: return 32'hA443_0002;  // sh   r3,2(r2)
      32'h20C: return 32'hAC43_0000;  // sw   r3,0(r2)
      default: return 32'hFC00_0000;  // opcode 0x3F
    endcase
  endfunction

  // Memory side: two wait cycles on the first fetch of 0x104; Zero=1 except on the second beq pass.
  assign bus.imem_data  = rom(bus.imem_addr);
  assign bus.imem_ready = !(bus.imem_addr == 32'h104 && stall_cnt < 2);
  assign Zero           = (beq_seen != 2);

  always @(posedge clk) begin
    if (bus.imem_req && !bus.imem_ready && bus.imem_addr == 32'h104) stall_cnt <= stall_cnt + 1;
    if (bus.imem_req && bus.imem_ready && bus.imem_addr == 32'h200) beq_seen <= beq_seen + 1;
  end

  function automatic logic [63:0] pk_rst(input logic req, input logic rw, input logic [1:0] mw,
                                         input logic mr, input logic mtr, input logic hl,
                                         input logic fnz, input logic [31:0] p);
    return {24'd0, req, rw, mw, mr, mtr, hl, fnz, p};
  endfunction

  function automatic logic [63:0] pk_fetch(input int cpi, input logic [31:0] a);
    return {24'd0, cpi[7:0], a};
  endfunction

  function automatic logic [63:0] pk_dec(input logic rw, input logic [1:0] mw, input logic mr,
                                         input logic mtr, input logic [1:0] op, input logic asel,
                                         input logic rsel, input logic [31:0] p);
    return {23'd0, rw, mw, mr, mtr, op, asel, rsel, p};
  endfunction

  function automatic logic [63:0] pk_wb(input int c, input logic rsel, input logic mtr,
                                        input logic mr, input logic [4:0] d, input logic [4:0] t);
    return {43'd0, c[7:0], rsel, mtr, mr, d, t};
  endfunction

  function automatic logic [63:0] pk_mem(input int c, input logic [1:0] mw, input logic mr,
                                         input logic [1:0] op, input logic asel, input logic rw);
    return {49'd0, c[7:0], mw, mr, op, asel, rw};
  endfunction

  function automatic logic [63:0] pk_halt(input int c, input logic hl, input logic req);
    return {54'd0, c[7:0], hl, req};
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_RST:   return "reset_state";
      K_FETCH: return "fetch";
      K_DEC:   return "decode";
      K_WB:    return "writeback";
      K_MEM:   return "mem_strobe";
      default: return "halt";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input logic [63:0] data, input logic [63:0] mask = M_ALL);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.mask = mask;
    q.push_back(e);
  endtask

  task automatic check(input int kind, input logic [63:0] obs);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got %h, required no event", kname(kind), obs);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || ((obs ^ e.data) & e.mask) != 64'd0) begin
        n_fail++;
        $display("FAIL %s: got %s %h, required %s %h", kname(e.kind), kname(kind), obs & e.mask,
                 kname(e.kind), e.data & e.mask);
      end
    end
  endtask

  // Monitor: classify what the DUT shows in each cycle and score it against the queue.
  always @(negedge clk) begin
    logic [63:0] obs;
    int          kind;
    bit          ev;
    ev   = 1'b1;
    kind = K_RST;
    obs  = '0;
    if (rst) begin
      icyc      = 0;
      dec_next  = 1'b0;
      halt_seen = 1'b0;
      obs = pk_rst(bus.imem_req, RegWrite, MemWrite, MemRead, MemToRegSel, halt,
                   |{rs, rt, rd, SEin, FuncCode}, pc);
    end else begin
      icyc++;
      if (bus.imem_req && bus.imem_ready) begin
        kind     = K_FETCH;
        obs      = pk_fetch(icyc - 1, bus.imem_addr);
        icyc     = 1;
        dec_next = 1'b1;
      end else if (dec_next) begin
        kind     = K_DEC;
        obs      = pk_dec(RegWrite, MemWrite, MemRead, MemToRegSel, ALUOp, ALUsel, Regsel, pc);
        dec_next = 1'b0;
      end else if (halt != halt_seen) begin
        kind = K_HALT;
        obs  = pk_halt(icyc, halt, bus.imem_req);
      end else if (RegWrite) begin
        kind = K_WB;
        obs  = pk_wb(icyc, Regsel, MemToRegSel, MemRead, rd, rt);
      end else if (MemWrite != 2'b00 || MemRead) begin
        kind = K_MEM;
        obs  = pk_mem(icyc, MemWrite, MemRead, ALUOp, ALUsel, RegWrite);
      end else begin
        ev = 1'b0;
      end
      halt_seen = halt;
    end
    if (ev) check(kind, obs);
  end

  initial begin
    bit got;
    rst = 1'b1;

    // Program run from reset through the illegal opcode.
    expect_ev(K_RST,   pk_rst(0, 0, 2'b00, 0, 0, 0, 0, 32'h100));
    expect_ev(K_RST,   pk_rst(0, 0, 2'b00, 0, 0, 0, 0, 32'h100));
    expect_ev(K_FETCH, pk_fetch(0, 32'h100));
    expect_ev(K_DEC,   pk_dec(0, 2'b00, 0, 0, 2'b10, 0, 1, 32'h104));
    expect_ev(K_WB,    pk_wb(4, 1, 0, 0, 5'd3, 5'd2));
    expect_ev(K_FETCH, pk_fetch(6, 32'h104));
    expect_ev(K_DEC,   pk_dec(0, 2'b00, 0, 0, 2'b00, 1, 0, 32'h108));
    expect_ev(K_MEM,   pk_mem(4, 2'b00, 1, 2'b00, 1, 0));
    expect_ev(K_WB,    pk_wb(5, 0, 1, 1, 5'd0, 5'd3));
    expect_ev(K_FETCH, pk_fetch(5, 32'h108));
    expect_ev(K_DEC,   pk_dec(0, 2'b00, 0, 0, 2'b00, 1, 0, 32'h10C));
    expect_ev(K_MEM,   pk_mem(4, 2'b01, 0, 2'b00, 1, 0));
    expect_ev(K_FETCH, pk_fetch(4, 32'h10C));
    expect_ev(K_DEC,   pk_dec(0, 2'b00, 0, 0, 2'b00, 0, 0, 32'h110), M_NOALU);
    expect_ev(K_FETCH, pk_fetch(3, 32'h200));
    expect_ev(K_DEC,   pk_dec(0, 2'b00, 0, 0, 2'b01, 0, 0, 32'h204));
    expect_ev(K_FETCH, pk_fetch(3, 32'h200));
    expect_ev(K_DEC,   pk_dec(0, 2'b00, 0, 0, 2'b01, 0, 0, 32'h204));
    expect_ev(K_FETCH, pk_fetch(3, 32'h204));
    expect_ev(K_DEC,   pk_dec(0, 2'b00, 0, 0, 2'b00, 1, 0, 32'h208));
    expect_ev(K_WB,    pk_wb(4, 0, 0, 0, 5'd0, 5'd1));
    expect_ev(K_FETCH, pk_fetch(4, 32'h208));
    expect_ev(K_DEC,   pk_dec(0, 2'b00, 0, 0, 2'b00, 1, 0, 32'h20C));
    expect_ev(K_MEM,   pk_mem(4, 2'b10, 0, 2'b00, 1, 0));
    expect_ev(K_FETCH, pk_fetch(4, 32'h20C));
    expect_ev(K_DEC,   pk_dec(0, 2'b00, 0, 0, 2'b00, 1, 0, 32'h210));
    expect_ev(K_MEM,   pk_mem(4, 2'b11, 0, 2'b00, 1, 0));
    expect_ev(K_FETCH, pk_fetch(4, 32'h210));
    expect_ev(K_DEC,   pk_dec(0, 2'b00, 0, 0, 2'b00, 0, 0, 32'h214), M_STRB);
    expect_ev(K_HALT,  pk_halt(3, 1, 0));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = halt;
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL halt_timeout: got halt=0 after 300 cycles, required halt=1");
    end
    repeat (5) @(posedge clk);
    #1;

    // Reset out of HALT, then a reset in the middle of an add's EXEC cycle.
    expect_ev(K_RST,   pk_rst(0, 0, 2'b00, 0, 0, 0, 0, 32'h100));
    expect_ev(K_FETCH, pk_fetch(0, 32'h100));
    expect_ev(K_DEC,   pk_dec(0, 2'b00, 0, 0, 2'b10, 0, 1, 32'h104));
    expect_ev(K_RST,   pk_rst(0, 0, 2'b00, 0, 0, 0, 0, 32'h100));
    expect_ev(K_FETCH, pk_fetch(0, 32'h100));
    expect_ev(K_DEC,   pk_dec(0, 2'b00, 0, 0, 2'b10, 0, 1, 32'h104));
    expect_ev(K_WB,    pk_wb(4, 1, 0, 0, 5'd3, 5'd2));
    expect_ev(K_FETCH, pk_fetch(4, 32'h104));
    expect_ev(K_DEC,   pk_dec(0, 2'b00, 0, 0, 2'b00, 1, 0, 32'h108));

    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d events still pending, required 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, required completion");
    $fatal(1);
  end

endmodule
